// File: rtl/rst_seq_fpga.sv
// Reset sequencer: synchronises and debounces the board reset sources, waits for PLL lock,
// holds the system reset for a fixed time and reports the cause. Optional sticky cause: RST_SEQ_CAUSE_STICKY_EN.
module rst_seq_fpga #(
  parameter int unsigned DebounceCycles = 16,
  parameter int unsigned HoldCycles     = 32,
  parameter int unsigned SyncStages     = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       btn_rst_ni,
  input  logic       jtag_srst_ni,
  input  logic       pll_locked_i,
`ifdef RST_SEQ_CAUSE_STICKY_EN
  input  logic       cause_clr_i,
`endif
  output logic       rst_sys_no,
  output logic       rst_active_o,
  output logic [1:0] rst_cause_o
);

  localparam logic [15:0] DbLast   = 16'(DebounceCycles - 1);
  localparam logic [15:0] HoldLast = 16'(HoldCycles - 1);

  typedef enum logic [1:0] {ST_RESET, ST_WAIT, ST_HOLD, ST_RUN} state_e;

  logic [SyncStages-1:0] btn_sync_q, srst_sync_q, lock_sync_q;
  logic                  btn_s, srst_s, lock_s;
  logic                  btn_db_q, srst_db_q;
  logic [15:0]           btn_cnt_q, srst_cnt_q;
  logic                  ok;
  state_e                state_q, state_d;
  logic [15:0]           hold_cnt_q, hold_cnt_d;
  logic                  run_exit;
  logic [1:0]            new_cause;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      btn_sync_q  <= '0;
      srst_sync_q <= '0;
      lock_sync_q <= '0;
    end else begin
      btn_sync_q  <= {btn_sync_q[SyncStages-2:0], btn_rst_ni};
      srst_sync_q <= {srst_sync_q[SyncStages-2:0], jtag_srst_ni};
      lock_sync_q <= {lock_sync_q[SyncStages-2:0], pll_locked_i};
    end
  end

  assign btn_s  = btn_sync_q[SyncStages-1];
  assign srst_s = srst_sync_q[SyncStages-1];
  assign lock_s = lock_sync_q[SyncStages-1];

  // A debounced value only follows its input after DebounceCycles consecutive differing samples
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      btn_db_q  <= 1'b0;
      btn_cnt_q <= '0;
    end else if (btn_s == btn_db_q) begin
      btn_cnt_q <= '0;
    end else if (btn_cnt_q == DbLast) begin
      btn_db_q  <= btn_s;
      btn_cnt_q <= '0;
    end else begin
      btn_cnt_q <= btn_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      srst_db_q  <= 1'b0;
      srst_cnt_q <= '0;
    end else if (srst_s == srst_db_q) begin
      srst_cnt_q <= '0;
    end else if (srst_cnt_q == DbLast) begin
      srst_db_q  <= srst_s;
      srst_cnt_q <= '0;
    end else begin
      srst_cnt_q <= srst_cnt_q + 16'd1;
    end
  end

  assign ok = lock_s & btn_db_q & srst_db_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_RESET;
      hold_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    run_exit   = 1'b0;
    case (state_q)
      ST_RESET: begin
        state_d    = ST_WAIT;
        hold_cnt_d = '0;
      end
      ST_WAIT: begin
        hold_cnt_d = '0;
        if (ok) state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (!ok) begin
          state_d    = ST_WAIT;
          hold_cnt_d = '0;
        end else if (hold_cnt_q == HoldLast) begin
          state_d    = ST_RUN;
          hold_cnt_d = '0;
        end else begin
          hold_cnt_d = hold_cnt_q + 16'd1;
        end
      end
      ST_RUN: begin
        if (!ok) begin
          state_d  = ST_WAIT;
          run_exit = 1'b1;
        end
      end
      default: state_d = ST_RESET;
    endcase
  end

  // Lock loss outranks the button, which outranks the JTAG request
  assign new_cause = !lock_s   ? 2'b01 :
                     !btn_db_q ? 2'b10 : 2'b11;

`ifdef RST_SEQ_CAUSE_STICKY_EN
  logic armed_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rst_cause_o <= 2'b00;
      armed_q     <= 1'b1;
    end else if (run_exit && (armed_q || cause_clr_i)) begin
      rst_cause_o <= new_cause;
      armed_q     <= 1'b0;
    end else if (cause_clr_i) begin
      rst_cause_o <= 2'b00;
      armed_q     <= 1'b1;
    end
  end
`else
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rst_cause_o <= 2'b00;
    end else if (run_exit) begin
      rst_cause_o <= new_cause;
    end
  end
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) rst_sys_no <= 1'b0;
    else       rst_sys_no <= (state_q == ST_RUN);
  end

  assign rst_active_o = (state_q != ST_RUN);

endmodule

// File: tb/tb_rst_seq_fpga.sv
// Bench for rst_seq_fpga with a window/streak reference model checked every cycle.
// Build with RST_SEQ_CAUSE_STICKY_EN defined to exercise the sticky cause register.
module tb_rst_seq_fpga;

  localparam int D = 8;
  localparam int H = 4;
  localparam int S = 2;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b0;
  logic       btn_rst_ni = 1'b1;
  logic       jtag_srst_ni = 1'b1;
  logic       pll_locked_i = 1'b1;
  logic       cause_clr_i = 1'b0;
  logic       rst_sys_no;
  logic       rst_active_o;
  logic [1:0] rst_cause_o;

  int checks = 0;
  int failures = 0;

  always #5 clk_i = ~clk_i;

  rst_seq_fpga #(.DebounceCycles(D), .HoldCycles(H), .SyncStages(S)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .btn_rst_ni   (btn_rst_ni),
    .jtag_srst_ni (jtag_srst_ni),
    .pll_locked_i (pll_locked_i),
`ifdef RST_SEQ_CAUSE_STICKY_EN
    .cause_clr_i  (cause_clr_i),
`endif
    .rst_sys_no   (rst_sys_no),
    .rst_active_o (rst_active_o),
    .rst_cause_o  (rst_cause_o)
  );

  // Reference model: delay queues for the synchronisers, sample windows for debounce,
  // and an ok-streak length deciding when the system is running.
  logic       q_btn[$], q_srst[$], q_lock[$];
  logic       w_btn[$], w_srst[$];
  logic       m_btn_db, m_srst_db, m_in_run, m_rstn, m_first, m_armed;
  int         m_streak;
  logic [1:0] m_cause, new_cause;
  logic       lock_pre, btn_pre, srst_pre, ok_pre, all_diff, clr_pre;

  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      q_btn = {}; q_srst = {}; q_lock = {}; w_btn = {}; w_srst = {};
      for (int i = 0; i < S; i++) begin
        q_btn.push_back(1'b0); q_srst.push_back(1'b0); q_lock.push_back(1'b0);
      end
      m_btn_db = 0; m_srst_db = 0; m_in_run = 0; m_rstn = 0;
      m_first = 1; m_streak = 0; m_cause = 2'b00; m_armed = 1;
    end else begin
      lock_pre = q_lock[0];
      btn_pre  = q_btn[0];
      srst_pre = q_srst[0];
`ifdef RST_SEQ_CAUSE_STICKY_EN
      clr_pre = cause_clr_i;
`else
      clr_pre = 1'b0;
`endif
      ok_pre = lock_pre & m_btn_db & m_srst_db;
      m_rstn = m_in_run;
      if (m_first) m_first = 0;
      else if (ok_pre) m_streak++;
      else m_streak = 0;
      new_cause = !lock_pre ? 2'b01 : (!m_btn_db ? 2'b10 : 2'b11);
`ifdef RST_SEQ_CAUSE_STICKY_EN
      if (m_in_run && !ok_pre && (m_armed || clr_pre)) begin
        m_cause = new_cause; m_armed = 0;
      end else if (clr_pre) begin
        m_cause = 2'b00; m_armed = 1;
      end
`else
      if (m_in_run && !ok_pre) m_cause = new_cause;
`endif
      m_in_run = (m_streak >= H + 1);
      q_btn.push_back(btn_rst_ni);    void'(q_btn.pop_front());
      q_srst.push_back(jtag_srst_ni); void'(q_srst.pop_front());
      q_lock.push_back(pll_locked_i); void'(q_lock.pop_front());
      w_btn.push_back(btn_pre);
      if (w_btn.size() > D) void'(w_btn.pop_front());
      if (w_btn.size() == D) begin
        all_diff = 1;
        foreach (w_btn[i]) if (w_btn[i] == m_btn_db) all_diff = 0;
        if (all_diff) m_btn_db = !m_btn_db;
      end
      w_srst.push_back(srst_pre);
      if (w_srst.size() > D) void'(w_srst.pop_front());
      if (w_srst.size() == D) begin
        all_diff = 1;
        foreach (w_srst[i]) if (w_srst[i] == m_srst_db) all_diff = 0;
        if (all_diff) m_srst_db = !m_srst_db;
      end
    end
  end

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic btn, input logic srst, input logic lock);
    btn_rst_ni   = btn;
    jtag_srst_ni = srst;
    pll_locked_i = lock;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_i);
    #2;
  endtask

  // Counts clock edges until the selected output reaches target (bounded)
  task automatic measure(input bit use_active, input logic target, output int n);
    n = 0;
    while (n < 200) begin
      @(posedge clk_i);
      #2;
      n++;
      if ((use_active ? rst_active_o : rst_sys_no) == target) break;
    end
  endtask

  task automatic clearCause();
`ifdef RST_SEQ_CAUSE_STICKY_EN
    cause_clr_i = 1'b1;
    tick(1);
    cause_clr_i = 1'b0;
    checkOutput("clear_cause", rst_cause_o, 0);
`endif
  endtask

  always @(negedge clk_i) begin
    if (rst_i) begin
      checkOutput("rst_sysn", rst_sys_no, 0);
      checkOutput("rst_active", rst_active_o, 1);
      checkOutput("rst_cause", rst_cause_o, 0);
    end else begin
      checkOutput("model_sysn", rst_sys_no, m_rstn);
      checkOutput("model_active", rst_active_o, !m_in_run);
      checkOutput("model_cause", rst_cause_o, m_cause);
    end
  end

  initial begin
    int n;
    #1 rst_i = 1'b1;
    applyStimulus(1, 1, 1);
    tick(3);
    rst_i = 1'b0;
    measure(0, 1, n);
    checkOutput("por_latency", n, 16);
    checkOutput("por_cause", rst_cause_o, 0);

    applyStimulus(0, 1, 1);
    tick(5);
    applyStimulus(1, 1, 1);
    tick(12);
    checkOutput("glitch_sysn", rst_sys_no, 1);
    checkOutput("glitch_active", rst_active_o, 0);

    applyStimulus(0, 1, 1);
    measure(1, 1, n);
    checkOutput("btn_active_latency", n, 11);
    measure(0, 0, n);
    checkOutput("btn_sysn_extra", n, 1);
    tick(8);
    checkOutput("btn_cause", rst_cause_o, 2);
    applyStimulus(1, 1, 1);
    measure(0, 1, n);
    checkOutput("btn_rerelease", n, 16);

    clearCause();
    applyStimulus(1, 0, 0);
    measure(1, 1, n);
    checkOutput("lock_active_latency", n, 3);
    measure(0, 0, n);
    checkOutput("lock_sysn_extra", n, 1);
    tick(16);
    checkOutput("lock_cause", rst_cause_o, 1);
    applyStimulus(1, 1, 0);
    tick(20);

    applyStimulus(1, 1, 1);
    tick(3);
    applyStimulus(1, 1, 0);
    tick(4);
    checkOutput("hold_drop_active", rst_active_o, 1);
    checkOutput("hold_drop_sysn", rst_sys_no, 0);
    applyStimulus(1, 1, 1);
    measure(0, 1, n);
    checkOutput("hold_rerelease", n, 8);
    checkOutput("hold_cause", rst_cause_o, 1);

    clearCause();
    applyStimulus(0, 1, 1);
    tick(20);
    applyStimulus(1, 1, 1);
    measure(0, 1, n);
    checkOutput("second_btn_rerelease", n, 16);
    checkOutput("second_btn_cause", rst_cause_o, 2);
    applyStimulus(1, 1, 0);
    tick(6);
    applyStimulus(1, 1, 1);
    measure(0, 1, n);
    checkOutput("relock_latency", n, 8);
`ifdef RST_SEQ_CAUSE_STICKY_EN
    checkOutput("sticky_cause_kept", rst_cause_o, 2);
    clearCause();
`else
    checkOutput("cause_overwritten", rst_cause_o, 1);
`endif

    rst_i = 1'b1;
    #1;
    checkOutput("async_sysn", rst_sys_no, 0);
    checkOutput("async_active", rst_active_o, 1);
    checkOutput("async_cause", rst_cause_o, 0);
    tick(2);
    rst_i = 1'b0;
    measure(0, 1, n);
    checkOutput("post_async_latency", n, 16);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
